// File: rtl/div_pkg.sv
// Shared constants and the in-flight tag type for the divider arbiter.
package div_pkg;
   localparam int DW          = 16;
   localparam int FW          = 2;
   localparam int LAT_DEFAULT = 20;
   localparam logic [15:0] DZ_QUOT = 16'hFFFF;
   // Tag id is sized for the largest supported requester count (4).
   localparam int IDW = 2;

   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
      logic           dz;
   } div_tag_t;
endpackage

// File: rtl/div_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner when the grant is taken.
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   ptr
);
   logic [PW-1:0] gidx;
   logic [PW-1:0] nxt;
   logic          found;
   int            idx;

   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            gidx       = PW'(idx);
            found      = 1'b1;
         end
      end
      nxt = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)          ptr <= '0;
      else if (advance) ptr <= nxt;
   end
endmodule

// File: rtl/div_arbiter.sv
// Shares one pipelined divider core between NREQ requesters; tags follow each
// division through the core so results return to their owner in order.
module div_arbiter #(
   parameter int NREQ = 2,
   parameter int LAT  = div_pkg::LAT_DEFAULT,
   parameter int DW   = div_pkg::DW,
   parameter int FW   = div_pkg::FW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DW-1:0]       req_dividend,
   input  logic [NREQ*DW-1:0]       req_divisor,
   output logic [NREQ-1:0]          req_ready,
   output logic [NREQ-1:0]          res_valid,
   output logic [DW-1:0]            res_quot,
   output logic [FW-1:0]            res_frac,
   output logic                     res_dz,
   output logic [$clog2(LAT+3)-1:0] inflight,
   output logic [DW-1:0]            div_inp1,
   output logic [DW-1:0]            div_inp2,
   input  logic                     div_rfd,
   input  logic [DW-1:0]            div_oup,
   input  logic [FW-1:0]            div_frac
);
   import div_pkg::*;

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IW = $clog2(LAT + 3);

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   gid;
   logic            accept;
   logic            ret;
   logic [DW-1:0]   sel_dvd;
   logic [DW-1:0]   sel_dvs;
   logic [NREQ-1:0] ret_vec;
   div_tag_t        issue_tag;
   div_tag_t        out_tag;
   div_tag_t        tag_pipe [LAT];

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant),
      .ptr     (rr_ptr)
   );

   always_comb begin
      req_ready = (rst || !div_rfd) ? '0 : grant;
      accept    = |req_ready;
      gid       = '0;
      for (int i = 0; i < NREQ; i++)
         if (grant[i]) gid = PW'(i);
      sel_dvd = req_dividend[int'(gid)*DW +: DW];
      sel_dvs = req_divisor[int'(gid)*DW +: DW];
   end

   // issue_tag sits beside div_inp1/2, so after LAT more stages it meets the core output.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_inp1  <= '0;
         div_inp2  <= '0;
         issue_tag <= '0;
      end else begin
         issue_tag <= '0;
         if (accept) begin
            div_inp1        <= sel_dvd;
            div_inp2        <= sel_dvs;
            issue_tag.valid <= 1'b1;
            issue_tag.id    <= IDW'(gid);
            issue_tag.dz    <= (sel_dvs == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) tag_pipe[k] <= '0;
      end else begin
         tag_pipe[0] <= issue_tag;
         for (int k = 1; k < LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
   end

   assign out_tag = tag_pipe[LAT-1];

   always_comb begin
      ret_vec = '0;
      for (int i = 0; i < NREQ; i++)
         ret_vec[i] = out_tag.valid && (out_tag.id == IDW'(i));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= '0;
         res_quot  <= '0;
         res_frac  <= '0;
         res_dz    <= 1'b0;
      end else begin
         res_valid <= ret_vec;
         if (out_tag.valid) begin
            res_dz <= out_tag.dz;
            if (out_tag.dz) begin
               res_quot <= DW'(DZ_QUOT);
               res_frac <= '0;
            end else begin
               res_quot <= div_oup;
               res_frac <= div_frac;
            end
         end
      end
   end

   assign ret = |res_valid;

   always_ff @(posedge clk) begin
      if (rst)                  inflight <= '0;
      else if (accept && !ret)  inflight <= inflight + IW'(1);
      else if (!accept && ret)  inflight <= inflight - IW'(1);
   end

   a_ptr_reset: assert property (@(posedge clk) rst |=> rr_ptr == '0);
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural LAT-cycle divider core.
module tb_div_arbiter;
   localparam int NREQ = 2;
   localparam int LAT  = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [31:0] req_dividend;
   logic [31:0] req_divisor;
   logic [1:0]  req_ready;
   logic [1:0]  res_valid;
   logic [15:0] res_quot;
   logic [1:0]  res_frac;
   logic        res_dz;
   logic [4:0]  inflight;
   logic [15:0] div_inp1;
   logic [15:0] div_inp2;
   logic        div_rfd;
   logic [15:0] div_oup;
   logic [1:0]  div_frac;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   div_arbiter #(.NREQ(NREQ), .LAT(LAT), .DW(16), .FW(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_dividend(req_dividend),
      .req_divisor(req_divisor), .req_ready(req_ready), .res_valid(res_valid),
      .res_quot(res_quot), .res_frac(res_frac), .res_dz(res_dz), .inflight(inflight),
      .div_inp1(div_inp1), .div_inp2(div_inp2), .div_rfd(div_rfd),
      .div_oup(div_oup), .div_frac(div_frac)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: output in cycle c reflects div_inp1/2 from cycle c-LAT.
   logic [15:0] h1 [LAT];
   logic [15:0] h2 [LAT];
   logic [31:0] rem4;
   initial for (int k = 0; k < LAT; k++) begin h1[k] = '0; h2[k] = '0; end
   always @(posedge clk) begin
      for (int k = LAT - 1; k > 0; k--) begin
         h1[k] <= h1[k-1];
         h2[k] <= h2[k-1];
      end
      h1[0] <= div_inp1;
      h2[0] <= div_inp2;
   end
   always_comb begin
      div_oup  = '0;
      div_frac = '0;
      rem4     = '0;
      if (h2[LAT-1] != 0) begin
         div_oup  = h1[LAT-1] / h2[LAT-1];
         rem4     = {16'b0, h1[LAT-1] % h2[LAT-1]} << 2;
         rem4     = rem4 / {16'b0, h2[LAT-1]};
         div_frac = rem4[1:0];
      end
   end

   int          acc_c[$];
   logic [1:0]  acc_v[$];
   int          r_c[$];
   logic [1:0]  r_v[$];
   logic [15:0] r_q[$];
   logic [1:0]  r_f[$];
   logic        r_d[$];

   always @(negedge clk) begin
      if (|(req_valid & req_ready)) begin
         acc_c.push_back(cyc);
         acc_v.push_back(req_valid & req_ready);
      end
      if (|res_valid) begin
         r_c.push_back(cyc);
         r_v.push_back(res_valid);
         r_q.push_back(res_quot);
         r_f.push_back(res_frac);
         r_d.push_back(res_dz);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acc_c.delete(); acc_v.delete();
      r_c.delete(); r_v.delete(); r_q.delete(); r_f.delete(); r_d.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      div_rfd = 1'b1;
      step();
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_res(input int n, input string tag);
      int k = 0;
      while (r_c.size() < n && k < 60) begin
         step();
         k++;
      end
      checks++;
      if (r_c.size() < n) begin
         errors++;
         $display("FAIL %s_timeout got %0d results want %0d", tag, r_c.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b11;
      req_dividend = {16'd5, 16'd6};
      req_divisor  = {16'd1, 16'd2};
      div_rfd = 1'b1;
      step();
      step();
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
      checks++; if (res_valid !== 2'b00) begin errors++; $display("FAIL reset_res_valid got %b want 00", res_valid); end
      checks++; if (res_quot !== 16'd0) begin errors++; $display("FAIL reset_quot got %h want 0", res_quot); end
      checks++; if (res_frac !== 2'd0 || res_dz !== 1'b0) begin errors++; $display("FAIL reset_frac_dz got %b/%b want 00/0", res_frac, res_dz); end
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
      checks++; if (div_inp1 !== 16'd0 || div_inp2 !== 16'd0) begin errors++; $display("FAIL reset_inp got %0d/%0d want 0/0", div_inp1, div_inp2); end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
      req_valid = '0;
      step();
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 2'b01;
      req_dividend = {16'd0, 16'd10};
      req_divisor  = {16'd0, 16'd4};
      step();
      req_valid = '0;
      checks++; if (inflight !== 5'd1) begin errors++; $display("FAIL single_inflight1 got %0d want 1", inflight); end
      wait_res(1, "single");
      checks++; if (acc_c.size() != 1 || acc_v[0] !== 2'b01) begin errors++; $display("FAIL single_accept got %0d accepts want 1 on req0", acc_c.size()); end
      checks++; if (r_c[0] - acc_c[0] != 22) begin errors++; $display("FAIL single_latency got %0d want 22", r_c[0] - acc_c[0]); end
      checks++; if (r_v[0] !== 2'b01) begin errors++; $display("FAIL single_owner got %b want 01", r_v[0]); end
      checks++; if (r_q[0] !== 16'd2 || r_f[0] !== 2'b10 || r_d[0] !== 1'b0) begin errors++; $display("FAIL single_value got q=%0d f=%b dz=%b want q=2 f=10 dz=0", r_q[0], r_f[0], r_d[0]); end
      step();
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL single_inflight0 got %0d want 0", inflight); end
      checks++; if (r_c.size() != 1) begin errors++; $display("FAIL single_extra got %0d pulses want 1", r_c.size()); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_q [4];
      logic [1:0]  exp_v [4];
      exp_q = '{16'd20, 16'd3, 16'd25, 16'd1};
      exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};
      do_reset();
      req_valid = 2'b11;
      req_dividend = {16'd9, 16'd100};
      req_divisor  = {16'd3, 16'd5};
      step();
      req_dividend = {16'd9, 16'd50};
      req_divisor  = {16'd3, 16'd2};
      step();
      req_dividend = {16'd8, 16'd50};
      req_divisor  = {16'd8, 16'd2};
      step();
      step();
      req_valid = '0;
      wait_res(4, "b2b");
      for (int i = 0; i < 4; i++) begin
         checks++; if (acc_v[i] !== exp_v[i] || acc_c[i] != acc_c[0] + i) begin errors++; $display("FAIL b2b_grant%0d got %b at +%0d want %b at +%0d", i, acc_v[i], acc_c[i] - acc_c[0], exp_v[i], i); end
         checks++; if (r_v[i] !== exp_v[i] || r_q[i] !== exp_q[i] || r_d[i] !== 1'b0) begin errors++; $display("FAIL b2b_result%0d got %b q=%0d dz=%b want %b q=%0d dz=0", i, r_v[i], r_q[i], r_d[i], exp_v[i], exp_q[i]); end
         checks++; if (r_c[i] != acc_c[0] + 22 + i) begin errors++; $display("FAIL b2b_timing%0d got +%0d want +%0d", i, r_c[i] - acc_c[0], 22 + i); end
      end
   endtask

   task automatic test_div_zero();
      do_reset();
      req_valid = 2'b10;
      req_dividend = {16'd7, 16'd0};
      req_divisor  = {16'd0, 16'd0};
      step();
      req_dividend = {16'd6, 16'd0};
      req_divisor  = {16'd3, 16'd0};
      step();
      req_valid = '0;
      wait_res(2, "dz");
      checks++; if (r_c[0] - acc_c[0] != 22 || r_v[0] !== 2'b10) begin errors++; $display("FAIL dz_timing got %b at +%0d want 10 at +22", r_v[0], r_c[0] - acc_c[0]); end
      checks++; if (r_q[0] !== 16'hFFFF || r_f[0] !== 2'b00 || r_d[0] !== 1'b1) begin errors++; $display("FAIL dz_value got q=%h f=%b dz=%b want q=ffff f=00 dz=1", r_q[0], r_f[0], r_d[0]); end
      checks++; if (r_v[1] !== 2'b10 || r_q[1] !== 16'd2 || r_f[1] !== 2'b00 || r_d[1] !== 1'b0) begin errors++; $display("FAIL dz_next got %b q=%0d f=%b dz=%b want 10 q=2 f=00 dz=0", r_v[1], r_q[1], r_f[1], r_d[1]); end
   endtask

   task automatic test_rfd_stall();
      do_reset();
      req_valid = 2'b01;
      req_dividend = {16'd0, 16'd12};
      req_divisor  = {16'd0, 16'd3};
      step();
      div_rfd = 1'b0;
      req_dividend = {16'd0, 16'd40};
      req_divisor  = {16'd0, 16'd8};
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready%0d got %b want 00", i, req_ready); end
         checks++; if (div_inp1 !== 16'd12 || div_inp2 !== 16'd3) begin errors++; $display("FAIL stall_hold%0d got %0d/%0d want 12/3", i, div_inp1, div_inp2); end
         step();
      end
      div_rfd = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_resume got %b want 01", req_ready); end
      step();
      req_valid = '0;
      checks++; if (div_inp1 !== 16'd40 || div_inp2 !== 16'd8) begin errors++; $display("FAIL stall_load got %0d/%0d want 40/8", div_inp1, div_inp2); end
      wait_res(2, "stall");
      checks++; if (acc_c.size() != 2 || acc_c[1] - acc_c[0] != 4) begin errors++; $display("FAIL stall_gap got %0d accepts gap %0d want 2 gap 4", acc_c.size(), acc_c[1] - acc_c[0]); end
      checks++; if (r_q[0] !== 16'd4 || r_q[1] !== 16'd5) begin errors++; $display("FAIL stall_values got %0d,%0d want 4,5", r_q[0], r_q[1]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 2'b01;
      req_dividend = {16'd0, 16'd10};
      req_divisor  = {16'd0, 16'd2};
      step(); step(); step();
      req_valid = '0;
      checks++; if (inflight !== 5'd3) begin errors++; $display("FAIL midrst_pre got %0d want 3", inflight); end
      step(); step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 30; i++) step();
      checks++; if (r_c.size() != 0) begin errors++; $display("FAIL midrst_dropped got %0d pulses want 0", r_c.size()); end
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL midrst_inflight got %0d want 0", inflight); end
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_ptr got %b want 01", req_ready); end
      step();
      req_valid = '0;
      wait_res(1, "midrst");
   endtask

   task automatic test_throughput();
      int peak = 0;
      do_reset();
      req_valid = 2'b10;
      for (int i = 0; i < 8; i++) begin
         req_dividend = {16'(3 * (i + 1)), 16'd0};
         req_divisor  = {16'd3, 16'd0};
         step();
         if (int'(inflight) > peak) peak = int'(inflight);
      end
      req_valid = '0;
      checks++; if (peak != 8 || acc_c.size() != 8) begin errors++; $display("FAIL tput_peak got %0d (%0d accepts) want 8", peak, acc_c.size()); end
      wait_res(8, "tput");
      step();
      for (int i = 0; i < 8; i++) begin
         checks++; if (r_v[i] !== 2'b10 || r_q[i] !== 16'(i + 1) || r_c[i] != r_c[0] + i) begin errors++; $display("FAIL tput_result%0d got %b q=%0d at +%0d want 10 q=%0d at +%0d", i, r_v[i], r_q[i], r_c[i] - r_c[0], i + 1, i); end
      end
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL tput_drain got %0d want 0", inflight); end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_dividend = '0;
      req_divisor = '0;
      div_rfd = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_div_zero();
      test_rfd_stall();
      test_reset_mid();
      test_throughput();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
